// File: rtl/srl_fifo_pkg.sv
// Shared types and helpers for the multi-channel shift-register FIFO.
// The status struct width follows the default configuration (DEPTH=4).
package srl_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_ADDR_WIDTH = clog2(DEF_DEPTH);
  localparam int CNT_W          = DEF_ADDR_WIDTH + 1;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             full_n;
    logic             empty_n;
    logic             afull;
    logic             ovf;
    logic             udf;
  } ch_status_t;

endpackage

// File: rtl/srl_fifo_mc_shiftreg.sv
// One channel of shift-register storage: shifts in on write, reads any tap.
// No reset so the array maps onto SRL primitives.
module srl_fifo_mc_shiftreg
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_srl[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_srl[i] <= r_srl[i-1];
      end
    end
  end

  assign dout = r_srl[addr];

endmodule

// File: rtl/srl_fifo_mc.sv
// Multi-channel first-word-fall-through FIFO over shift-register storage,
// with registered per-channel flags, occupancy and sticky error bits.
module srl_fifo_mc
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int NUM_CH     = 2,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH-1:0]                if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     if_din,
  output logic [NUM_CH-1:0]                if_full_n,
  output logic [NUM_CH-1:0]                if_almost_full,
  input  logic [NUM_CH-1:0]                if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0]     if_dout,
  output logic [NUM_CH-1:0]                if_empty_n,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] if_num_data,
  output logic [NUM_CH-1:0]                err_ovf,
  output logic [NUM_CH-1:0]                err_udf
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

  localparam ch_status_t RST_ST = '{
    count:   '0,
    full_n:  1'b1,
    empty_n: 1'b0,
    afull:   (AF_LEVEL == 0),
    ovf:     1'b0,
    udf:     1'b0
  };

  // Simultaneous accepted read and write keeps the count: the shift moves
  // the consumed head up to index count, leaving the new head at count-1.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic wr,
                                                  input logic rd);
    logic [CNT_W-1:0] n;
    n = cnt;
    case ({wr, rd})
      2'b10:   n = cnt + 1'b1;
      2'b01:   n = cnt - 1'b1;
      default: n = cnt;
    endcase
    return n;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] head_addr(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] m;
    m = cnt - 1'b1;
    return (cnt == '0) ? '0 : ADDR_WIDTH'(m);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_status_t            r_st;
    ch_status_t            w_nxt;
    logic                  w_wr;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_dout;

    assign w_wr = if_write[c] & r_st.full_n;
    assign w_rd = if_read[c] & r_st.empty_n;

    always_comb begin
      w_nxt         = r_st;
      w_nxt.count   = next_count(r_st.count, w_wr, w_rd);
      w_nxt.empty_n = (w_nxt.count != '0);
      w_nxt.full_n  = (w_nxt.count != CNT_FULL);
      w_nxt.afull   = (w_nxt.count >= CNT_AF);
      w_nxt.ovf     = r_st.ovf | (if_write[c] & ~r_st.full_n);
      w_nxt.udf     = r_st.udf | (if_read[c] & ~r_st.empty_n);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_st <= RST_ST;
      end else begin
        r_st <= w_nxt;
      end
    end

    assign w_addr = head_addr(r_st.count);

    srl_fifo_mc_shiftreg #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_srl (
      .clk (clk),
      .we  (w_wr),
      .addr(w_addr),
      .din (if_din[c*DATA_WIDTH +: DATA_WIDTH]),
      .dout(w_dout)
    );

    assign if_dout[c*DATA_WIDTH +: DATA_WIDTH]           = w_dout;
    assign if_num_data[c*(ADDR_WIDTH+1) +: ADDR_WIDTH+1] = r_st.count;
    assign if_full_n[c]      = r_st.full_n;
    assign if_empty_n[c]     = r_st.empty_n;
    assign if_almost_full[c] = r_st.afull;
    assign err_ovf[c]        = r_st.ovf;
    assign err_udf[c]        = r_st.udf;
  end

endmodule

// File: doc/srl_fifo_mc.md
Name: srl_fifo_mc

Overview:
- Multi-channel, first-word-fall-through FIFO with shift-register storage.
- Successor to the single-channel start/data shift-register helper; provides full FIFO control around the storage.
- Control per channel: occupancy counter, full/empty flags, almost-full flag, sticky overflow/underflow error flags.
- Sits between dataflow PEs in the linear-layer datapath: one instance carries NUM_CH independent streams, e.g. one per PE column.

Parameters:
- DATA_WIDTH, 8: bits per entry per channel (>=1).
- DEPTH, 4: entries per channel (>=2).
- ADDR_WIDTH, 2: $clog2(DEPTH); sized for the read address; the counter is one bit wider.
- NUM_CH, 2: number of independent channels.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL (1..DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_write  in  NUM_CH  per-channel write request.
- if_din  in  NUM_CH*DATA_WIDTH  write data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- if_full_n  out  NUM_CH  per-channel not-full, registered.
- if_almost_full  out  NUM_CH  count >= AF_LEVEL, registered.
- if_read  in  NUM_CH  per-channel read/pop request.
- if_dout  out  NUM_CH*DATA_WIDTH  head entry per channel, same packing as if_din; valid only while empty_n is high.
- if_empty_n  out  NUM_CH  per-channel not-empty, registered.
- if_num_data  out  NUM_CH*(ADDR_WIDTH+1)  per-channel occupancy, registered.
- err_ovf  out  NUM_CH  sticky: a write was attempted while full.
- err_udf  out  NUM_CH  sticky: a read was attempted while empty.

Behaviour:
- Channels are fully independent; the rules below apply per channel c.
- Accepted write: wr = if_write & if_full_n. Accepted read: rd = if_read & if_empty_n. No combinational path from if_read to if_full_n.
- Storage: SRL[0..DEPTH-1], not reset, so it maps to SRL primitives.
  - On wr: SRL[0] <= din and SRL[i+1] <= SRL[i] for all i.
  - SRL shifts only on wr; a read never shifts.
- Head: if_dout = SRL[count-1] when count > 0. When count == 0, dout is don't-care (drive SRL[0]).
  - Zero-latency look-ahead: a word written at edge N is visible at dout after edge N.
- Count update:
  - wr & !rd: +1.
  - rd & !wr: -1.
  - both: unchanged. The shift moves the consumed head to index count, so the new head is at count-1.
  - neither: unchanged.
- Flags, registered from next_count:
  - empty_n = (next_count != 0).
  - full_n = (next_count != DEPTH).
  - almost_full = (next_count >= AF_LEVEL).
- Full boundary: with count == DEPTH, if_write & if_read in the same cycle gives read accepted, write refused, count = DEPTH-1, err_ovf set.
- Empty boundary: with count == 0, a simultaneous write & read gives write accepted, read refused, count = 1, err_udf set.
- Errors: err_ovf |= if_write & ~if_full_n; err_udf |= if_read & ~if_empty_n. Both are cleared only by reset.
- Reset, asynchronous and also mid-stream:
  - count = 0, if_empty_n = 0, if_full_n = 1.
  - if_almost_full = (AF_LEVEL == 0 ? 1 : 0); AF_LEVEL >= 1 is required, so 0.
  - err_ovf = err_udf = 0.
  - Data in flight is discarded; storage contents are retained but unreachable.
- Throughput: one write and one read per channel per cycle sustained when 0 < count < DEPTH.

Decomposition:
- Shared package srl_fifo_pkg:
  - function clog2.
  - localparam CNT_W = ADDR_WIDTH+1.
  - typedef for the per-channel status struct (count, full_n, empty_n, afull, ovf, udf).
- Sub-module srl_fifo_mc_shiftreg: one channel's storage.
  - Ports: clk, we, addr, din, dout.
  - No reset.
  - Instantiated NUM_CH times by a generate loop next to the per-channel control.

Test Plan:
- Fill/drain ch0 (DEPTH=4): write 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Expected: empty_n rises after the 1st edge; almost_full after the 3rd; full_n=0 after the 4th; num_data=4.
  - Then read 4 cycles: dout shows 0x11,0x22,0x33,0x44 in order; empty_n=0 after the 4th read.
- Simultaneous R/W at count=2 (contents 0xA1,0xA2): write 0xA3 + read in the same cycle.
  - Expected: count stays 2; dout changes 0xA1 to 0xA2; then reads return 0xA2, 0xA3.
- Full boundary: fill to 4, assert write(0x55) + read together.
  - Expected: count=3, err_ovf[0]=1; 0x55 never appears on dout.
- Empty boundary: count=0, assert read + write(0x66).
  - Expected: count=1, err_udf[0]=1, next-cycle dout=0x66.
- Channel isolation: stream 0x01..0x08 into ch1 while ch0 is idle.
  - Expected: ch0 flags and count unchanged; ch1 data is in order, with backpressure through full_n.
- Async reset mid-stream at count=3: pulse reset between edges.
  - Expected: outputs immediately show empty_n=0, full_n=1, count=0, errors 0.
  - Next write 0x77 is read back as 0x77.
